// File: rtl/keypad_scanner.sv
// keypad_scanner: column scanner and debouncer for a 4x4 active-low hex keypad.
//
// Drives one column low at a time, samples the synchronised rows, and once a single
// key has been stable for DEBOUNCE_CYCLES it publishes the hex code together with a
// one-cycle strobe. The key must then be released (also debounced) before scanning
// resumes, so a held key never repeats.
//
// Ports:
//   clk              system clock
//   rst              asynchronous active-high reset
//   row[3:0]         keypad rows, active-low, asynchronous to clk
//   col[3:0]         column drive, active-low, exactly one bit low
//   key_code[3:0]    hex code of the last accepted key
//   is_a_key_pressed one-cycle strobe on press acceptance
//   key_held         high from press acceptance until the release is debounced
module keypad_scanner #(
  parameter int unsigned SCAN_CYCLES     = 1000,
  parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       is_a_key_pressed,
  output logic       key_held
);

  localparam int unsigned ScanW = $clog2(SCAN_CYCLES);
  localparam int unsigned DbW   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [ScanW-1:0] ScanLast = ScanW'(SCAN_CYCLES - 1);
  localparam logic [DbW-1:0]   DbLast   = DbW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {StScan, StDebounce, StHeld, StRelease} state_e;

  state_e           state_q, state_d;
  logic [3:0]       row_meta_q, row_s_q;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [ScanW-1:0] scan_cnt_q, scan_cnt_d;
  logic [DbW-1:0]   db_cnt_q, db_cnt_d;
  logic [DbW-1:0]   rel_cnt_q, rel_cnt_d;
  logic [1:0]       cand_row_q, cand_row_d;
  logic [1:0]       cand_col_q, cand_col_d;
  logic [3:0]       col_q, col_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             strobe_q, strobe_d;
  logic             key_held_q, key_held_d;

  logic             row_one;
  logic [1:0]       row_enc;
  logic [3:0]       cand_pat;

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'h0: k = 4'h1;
      4'h1: k = 4'h2;
      4'h2: k = 4'h3;
      4'h3: k = 4'hA;
      4'h4: k = 4'h4;
      4'h5: k = 4'h5;
      4'h6: k = 4'h6;
      4'h7: k = 4'hB;
      4'h8: k = 4'h7;
      4'h9: k = 4'h8;
      4'hA: k = 4'h9;
      4'hB: k = 4'hC;
      4'hC: k = 4'h0;
      4'hD: k = 4'hF;
      4'hE: k = 4'hE;
      default: k = 4'hD;
    endcase
    return k;
  endfunction

  // Two-flop synchroniser; idle rows read as all-high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_meta_q <= 4'hF;
      row_s_q    <= 4'hF;
    end else begin
      row_meta_q <= row;
      row_s_q    <= row_meta_q;
    end
  end

  // Exactly one row low is a valid single key; anything else is idle or ghosting.
  always_comb begin
    row_one = 1'b1;
    row_enc = 2'd0;
    case (row_s_q)
      4'b1110: row_enc = 2'd0;
      4'b1101: row_enc = 2'd1;
      4'b1011: row_enc = 2'd2;
      4'b0111: row_enc = 2'd3;
      default: row_one = 1'b0;
    endcase
  end

  assign cand_pat = ~(4'b0001 << cand_row_q);

  always_comb begin
    state_d    = state_q;
    col_idx_d  = col_idx_q;
    scan_cnt_d = scan_cnt_q;
    db_cnt_d   = db_cnt_q;
    rel_cnt_d  = rel_cnt_q;
    cand_row_d = cand_row_q;
    cand_col_d = cand_col_q;
    key_code_d = key_code_q;
    strobe_d   = 1'b0;
    key_held_d = key_held_q;

    unique case (state_q)
      StScan: begin
        if (scan_cnt_q == ScanLast) begin
          scan_cnt_d = '0;
          if (row_one) begin
            cand_row_d = row_enc;
            cand_col_d = col_idx_q;
            db_cnt_d   = '0;
            state_d    = StDebounce;
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end else begin
          scan_cnt_d = scan_cnt_q + ScanW'(1);
        end
      end
      StDebounce: begin
        if (row_s_q == cand_pat) begin
          if (db_cnt_q == DbLast) begin
            state_d    = StHeld;
            key_code_d = key_map(cand_row_q, cand_col_q);
            strobe_d   = 1'b1;
            key_held_d = 1'b1;
          end else begin
            db_cnt_d = db_cnt_q + DbW'(1);
          end
        end else begin
          // Bounce: rescan the same column from the start.
          state_d    = StScan;
          scan_cnt_d = '0;
        end
      end
      StHeld: begin
        if (row_s_q == 4'hF) begin
          state_d   = StRelease;
          rel_cnt_d = '0;
        end
      end
      StRelease: begin
        if (row_s_q == 4'hF) begin
          if (rel_cnt_q == DbLast) begin
            key_held_d = 1'b0;
            state_d    = StScan;
            col_idx_d  = col_idx_q + 2'd1;
            scan_cnt_d = '0;
          end else begin
            rel_cnt_d = rel_cnt_q + DbW'(1);
          end
        end else begin
          state_d = StHeld;
        end
      end
      default: state_d = StScan;
    endcase
  end

  // Column drive is registered from the next column index so it changes with col_idx_q.
  assign col_d = ~(4'b0001 << col_idx_d);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StScan;
      col_idx_q  <= 2'd0;
      scan_cnt_q <= '0;
      db_cnt_q   <= '0;
      rel_cnt_q  <= '0;
      cand_row_q <= 2'd0;
      cand_col_q <= 2'd0;
      col_q      <= 4'b1110;
      key_code_q <= 4'h0;
      strobe_q   <= 1'b0;
      key_held_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_idx_q  <= col_idx_d;
      scan_cnt_q <= scan_cnt_d;
      db_cnt_q   <= db_cnt_d;
      rel_cnt_q  <= rel_cnt_d;
      cand_row_q <= cand_row_d;
      cand_col_q <= cand_col_d;
      col_q      <= col_d;
      key_code_q <= key_code_d;
      strobe_q   <= strobe_d;
      key_held_q <= key_held_d;
    end
  end

  assign col              = col_q;
  assign key_code         = key_code_q;
  assign is_a_key_pressed = strobe_q;
  assign key_held         = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed testbench for keypad_scanner with a behavioural 4x4 keypad model.
module tb_keypad_scanner;

  logic       clk;
  logic       rst;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       is_a_key_pressed;
  logic       key_held;

  // pressed[r*4+c] closes the switch at row r, column c.
  logic [15:0] pressed;

  int n_checks;
  int n_errors;
  int strobe_cnt;
  logic [3:0] code_at_strobe;

  keypad_scanner #(
    .SCAN_CYCLES    (4),
    .DEBOUNCE_CYCLES(8)
  ) u_dut (
    .clk             (clk),
    .rst             (rst),
    .row             (row),
    .col             (col),
    .key_code        (key_code),
    .is_a_key_pressed(is_a_key_pressed),
    .key_held        (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
      end
    end
  end

  // Strobe monitor, sampled shortly after each rising edge.
  initial begin
    strobe_cnt     = 0;
    code_at_strobe = 4'h0;
  end
  always @(posedge clk) begin
    #2;
    if (is_a_key_pressed) begin
      strobe_cnt++;
      code_at_strobe = key_code;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic wait_strobe(input int s0, input int max_cyc, output int cyc);
    cyc = 0;
    while (strobe_cnt == s0 && cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic wait_held_low(input int max_cyc, output bit ok);
    int cyc;
    cyc = 0;
    while (key_held !== 1'b0 && cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
    end
    ok = (key_held === 1'b0);
  endtask

  task automatic wait_col(input logic [3:0] target, input bit equal, input int max_cyc);
    int cyc;
    cyc = 0;
    while (((col == target) != equal) && cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("wait_col", 32'(((col == target) == equal)), 32'd1);
  endtask

  initial begin
    int  s0;
    int  cyc;
    int  seen;
    bit  ok;
    logic [3:0] exp_col;

    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    pressed  = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check_eq("rst_col", col, 4'b1110);
    check_eq("rst_code", key_code, 4'h0);
    check_eq("rst_strobe", is_a_key_pressed, 1'b0);
    check_eq("rst_held", key_held, 1'b0);

    // Idle scan: each column held 4 cycles, rotating left to right
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      exp_col = ~(4'b0001 << ((k / 4) % 4));
      check_eq("idle_col", col, exp_col);
      @(negedge clk);
    end
    check_eq("idle_no_strobe", strobe_cnt, 0);
    check_eq("idle_code", key_code, 4'h0);

    // Clean press of '5' (r1,c1)
    s0 = strobe_cnt;
    pressed[5] = 1'b1;
    wait_strobe(s0, 60, cyc);
    check_eq("k5_strobe_seen", 32'(strobe_cnt != s0), 32'd1);
    check_eq("k5_code", code_at_strobe, 4'h5);
    check_eq("k5_held", key_held, 1'b1);
    check_eq("k5_col", col, 4'b1101);
    repeat (200) @(negedge clk);
    check_eq("k5_one_strobe", strobe_cnt - s0, 1);
    check_eq("k5_col_hold", col, 4'b1101);
    check_eq("k5_held_hold", key_held, 1'b1);
    pressed[5] = 1'b0;
    wait_held_low(30, ok);
    check_eq("k5_release", ok, 1'b1);
    check_eq("k5_next_col", col, 4'b1011);
    check_eq("k5_code_kept", key_code, 4'h5);

    // Bouncing press of 'D' (r3,c3): 3-cycle runs never reach 8 stable cycles
    s0 = strobe_cnt;
    for (int i = 0; i < 10; i++) begin
      pressed[15] = (i % 2 == 0);
      repeat (3) @(negedge clk);
    end
    check_eq("kd_bounce_no_strobe", strobe_cnt - s0, 0);
    pressed[15] = 1'b1;
    wait_strobe(s0, 60, cyc);
    check_eq("kd_strobe_seen", 32'(strobe_cnt != s0), 32'd1);
    check_eq("kd_min_latency", 32'(cyc >= 8), 32'd1);
    check_eq("kd_code", code_at_strobe, 4'hD);
    // Release bounce shorter than the debounce window
    for (int i = 0; i < 3; i++) begin
      pressed[15] = 1'b0;
      repeat (3) @(negedge clk);
      pressed[15] = 1'b1;
      repeat (3) @(negedge clk);
    end
    check_eq("kd_rel_bounce_held", key_held, 1'b1);
    check_eq("kd_one_strobe", strobe_cnt - s0, 1);
    pressed[15] = 1'b0;
    wait_held_low(30, ok);
    check_eq("kd_release", ok, 1'b1);

    // Ghost: '1' and '4' in column 0 together are rejected
    s0 = strobe_cnt;
    pressed[0] = 1'b1;
    pressed[4] = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (col == 4'b0111) seen++;
    end
    check_eq("ghost_no_strobe", strobe_cnt - s0, 0);
    check_eq("ghost_not_held", key_held, 1'b0);
    check_eq("ghost_scan_cycles", 32'(seen > 0), 32'd1);
    pressed[4] = 1'b0;
    wait_strobe(s0, 60, cyc);
    check_eq("ghost_k1_seen", 32'(strobe_cnt != s0), 32'd1);
    check_eq("ghost_k1_code", code_at_strobe, 4'h1);
    pressed[0] = 1'b0;
    wait_held_low(30, ok);
    check_eq("ghost_k1_release", ok, 1'b1);

    // Reset three cycles into DEBOUNCE of 'A' (r0,c3)
    wait_col(4'b0111, 1'b0, 40);
    wait_col(4'b0111, 1'b1, 40);
    pressed[3] = 1'b1;
    repeat (7) @(negedge clk);
    s0 = strobe_cnt;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_col", col, 4'b1110);
    check_eq("mid_rst_code", key_code, 4'h0);
    check_eq("mid_rst_strobe", is_a_key_pressed, 1'b0);
    check_eq("mid_rst_held", key_held, 1'b0);
    repeat (3) @(negedge clk);
    check_eq("mid_rst_no_strobe", strobe_cnt - s0, 0);
    rst = 1'b0;
    wait_strobe(s0, 60, cyc);
    check_eq("ka_strobe_seen", 32'(strobe_cnt != s0), 32'd1);
    check_eq("ka_code", code_at_strobe, 4'hA);
    repeat (5) @(negedge clk);
    check_eq("ka_one_strobe", strobe_cnt - s0, 1);
    pressed[3] = 1'b0;
    wait_held_low(30, ok);
    check_eq("ka_release", ok, 1'b1);

    // Key '0' (r3,c0), then 'F' (r3,c1)
    s0 = strobe_cnt;
    pressed[12] = 1'b1;
    wait_strobe(s0, 60, cyc);
    check_eq("k0_strobe_seen", 32'(strobe_cnt != s0), 32'd1);
    check_eq("k0_code", code_at_strobe, 4'h0);
    repeat (5) @(negedge clk);
    check_eq("k0_one_strobe", strobe_cnt - s0, 1);
    pressed[12] = 1'b0;
    wait_held_low(30, ok);
    check_eq("k0_release", ok, 1'b1);

    s0 = strobe_cnt;
    pressed[13] = 1'b1;
    wait_strobe(s0, 60, cyc);
    check_eq("kf_strobe_seen", 32'(strobe_cnt != s0), 32'd1);
    check_eq("kf_code", code_at_strobe, 4'hF);
    repeat (5) @(negedge clk);
    check_eq("kf_one_strobe", strobe_cnt - s0, 1);
    pressed[13] = 1'b0;
    wait_held_low(30, ok);
    check_eq("kf_release", ok, 1'b1);
    check_eq("kf_code_kept", key_code, 4'hF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
